// File: rtl/fwrisc_bus_pkg.sv
// rtl/fwrisc_bus_pkg.sv - shared encodings for the fetch/data bus arbiter
//
// Purpose: FSM state encoding and requester IDs used by fwrisc_bus_arb
//          and fwrisc_rr_arb2.
// Ports:   none (package).
package fwrisc_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/fwrisc_rr_arb2.sv
// rtl/fwrisc_rr_arb2.sv - combinational two-way winner select
//
// Purpose: picks fetch or data port from the current requests.
// Ports:
//   ivalid     in  fetch request
//   dvalid     in  data request
//   last_grant in  requester served by the previous completed transaction
//   any_req    out at least one request present
//   winner     out REQ_FETCH / REQ_DATA (meaningful only when any_req=1)
module fwrisc_rr_arb2
  import fwrisc_bus_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic ivalid,
  input  logic dvalid,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = ivalid | dvalid;
    winner  = REQ_FETCH;
    if (dvalid && !ivalid) begin
      winner = REQ_DATA;
    end else if (ivalid && dvalid) begin
      // Round-robin favours whichever port was not served last; the
      // reset value of last_grant (fetch) hands the first tie to data.
      if (DATA_PRIORITY) winner = REQ_DATA;
      else               winner = (last_grant == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end
  end

endmodule

// File: rtl/fwrisc_bus_arb.sv
// rtl/fwrisc_bus_arb.sv - fetch/data arbiter onto one valid/ready master port
//
// Purpose: serialises instruction-fetch and load/store requests onto a
//          single non-pipelined master interface, one access at a time.
// Ports:
//   clock, reset                 clock; async active-high reset
//   ivalid, iaddr                fetch request / address
//   irdata, iready               fetch read data / one-cycle completion pulse
//   dvalid, daddr, dwdata,
//   dwstb, dwrite                data request, address, write data, strobes, dir
//   drdata, dready               data read data / one-cycle completion pulse
//   mvalid, maddr, mwdata,
//   mwstb, mwrite                master request outputs
//   mrdata, mready               slave read data / completion
module fwrisc_bus_arb
  import fwrisc_bus_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ivalid,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        iready,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        mvalid,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  output logic        mwrite,
  input  logic [31:0] mrdata,
  input  logic        mready
);

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic       any_req;
  logic       winner;

  fwrisc_rr_arb2 #(
    .DATA_PRIORITY (DATA_PRIORITY)
  ) u_sel (
    .ivalid     (ivalid),
    .dvalid     (dvalid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= REQ_FETCH;
      last_grant <= REQ_FETCH;
      iready     <= 1'b0;
      dready     <= 1'b0;
      irdata     <= 32'h0;
      drdata     <= 32'h0;
      mvalid     <= 1'b0;
      maddr      <= 32'h0;
      mwdata     <= 32'h0;
      mwstb      <= 4'h0;
      mwrite     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant  <= winner;
            mvalid <= 1'b1;
            if (winner == REQ_DATA) begin
              maddr  <= daddr;
              mwdata <= dwdata;
              mwstb  <= dwstb;
              mwrite <= dwrite;
            end else begin
              maddr  <= iaddr;
              mwdata <= 32'h0;
              mwstb  <= 4'h0;
              mwrite <= 1'b0;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Write completions also capture mrdata; the requester ignores it.
          if (mready) begin
            if (grant == REQ_DATA) begin
              drdata <= mrdata;
              dready <= 1'b1;
            end else begin
              irdata <= mrdata;
              iready <= 1'b1;
            end
            mvalid     <= 1'b0;
            mwrite     <= 1'b0;
            mwstb      <= 4'h0;
            last_grant <= grant;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // The winner's valid is still high this cycle, so no arbitration.
          iready <= 1'b0;
          dready <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_bus_arb.sv
// tb/tb_fwrisc_bus_arb.sv - directed self-checking bench for fwrisc_bus_arb
module tb_fwrisc_bus_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        ivalid = 1'b0, dvalid = 1'b0, dwrite = 1'b0, mready = 1'b0;
  logic [31:0] iaddr = 32'h0, daddr = 32'h0, dwdata = 32'h0, mrdata = 32'h0;
  logic [3:0]  dwstb = 4'h0;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic        iready, dready, mvalid, mwrite;
  logic [3:0]  mwstb;

  logic        r_ivalid = 1'b0, r_dvalid = 1'b0, r_mready = 1'b0;
  logic [31:0] r_irdata, r_drdata, r_maddr, r_mwdata;
  logic        r_iready, r_dready, r_mvalid, r_mwrite;
  logic [3:0]  r_mwstb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fwrisc_bus_arb #(.DATA_PRIORITY(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ivalid(ivalid), .iaddr(iaddr), .irdata(irdata), .iready(iready),
    .dvalid(dvalid), .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .drdata(drdata), .dready(dready),
    .mvalid(mvalid), .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
    .mrdata(mrdata), .mready(mready)
  );

  fwrisc_bus_arb #(.DATA_PRIORITY(1'b0)) dut_rr (
    .clock(clock), .reset(reset),
    .ivalid(r_ivalid), .iaddr(iaddr), .irdata(r_irdata), .iready(r_iready),
    .dvalid(r_dvalid), .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .drdata(r_drdata), .dready(r_dready),
    .mvalid(r_mvalid), .maddr(r_maddr), .mwdata(r_mwdata), .mwstb(r_mwstb), .mwrite(r_mwrite),
    .mrdata(mrdata), .mready(r_mready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Both ports request continuously until each has completed n accesses.
  // order shifts in 1 for a data completion, 0 for a fetch completion.
  task automatic run_tie(input bit rr, input int n, output logic [7:0] order,
                         output int first_c, output int min_gap, output int max_gap);
    int  icnt = 0, dcnt = 0, last_c = 0;
    bit  done = 0;
    logic ir, dr;
    order = 8'h0; first_c = -1; min_gap = 1000; max_gap = 0;
    if (rr) begin r_ivalid = 1; r_dvalid = 1; r_mready = 1; end
    else    begin ivalid = 1;   dvalid = 1;   mready = 1;   end
    for (int c = 1; c <= 60 && !done; c++) begin
      tick();
      ir = rr ? r_iready : iready;
      dr = rr ? r_dready : dready;
      if (ir || dr) begin
        order = {order[6:0], dr};
        if (first_c < 0) first_c = c;
        else begin
          if (c - last_c < min_gap) min_gap = c - last_c;
          if (c - last_c > max_gap) max_gap = c - last_c;
        end
        last_c = c;
      end
      if (ir) begin
        icnt++;
        if (icnt == n) begin if (rr) r_ivalid = 0; else ivalid = 0; end
      end
      if (dr) begin
        dcnt++;
        if (dcnt == n) begin if (rr) r_dvalid = 0; else dvalid = 0; end
      end
      if (icnt == n && dcnt == n) done = 1;
    end
    check("tie_completed", {31'b0, done}, 32'd1);
    if (rr) r_mready = 0; else mready = 0;
    tick();
  endtask

  logic [7:0] order;
  int first_c, min_gap, max_gap;

  initial begin
    #1;
    check("rst_mvalid", {31'b0, mvalid}, 32'd0);
    check("rst_ready",  {30'b0, iready, dready}, 32'd0);
    check("rst_irdata", irdata, 32'h0);
    check("rst_drdata", drdata, 32'h0);
    check("rst_maddr",  maddr, 32'h0);
    check("rst_mwx",    {27'b0, mwrite, mwstb}, 32'd0);
    check("rst_mwdata", mwdata, 32'h0);
    tick();
    reset = 0;
    tick();

    // Fetch only, zero-wait slave.
    ivalid = 1; iaddr = 32'h100; mrdata = 32'hDEADBEEF; mready = 1;
    tick();
    check("f_mvalid", {31'b0, mvalid}, 32'd1);
    check("f_maddr",  maddr, 32'h100);
    check("f_mwrite", {31'b0, mwrite}, 32'd0);
    check("f_iready_early", {31'b0, iready}, 32'd0);
    tick();
    check("f_iready", {31'b0, iready}, 32'd1);
    check("f_irdata", irdata, 32'hDEADBEEF);
    check("f_dready", {31'b0, dready}, 32'd0);
    check("f_mvalid_done", {31'b0, mvalid}, 32'd0);
    ivalid = 0; mready = 0;
    tick();
    check("f_iready_pulse", {31'b0, iready}, 32'd0);
    tick();

    // Data write with three slave wait states.
    dvalid = 1; daddr = 32'h2002; dwdata = 32'hABCDABCD; dwstb = 4'b1100; dwrite = 1;
    mrdata = 32'h5555AAAA;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("w_mvalid", {31'b0, mvalid}, 32'd1);
      check("w_maddr",  maddr, 32'h2002);
      check("w_mwdata", mwdata, 32'hABCDABCD);
      check("w_mwstb_mwrite", {27'b0, mwrite, mwstb}, {27'b0, 1'b1, 4'b1100});
      check("w_dready_wait", {31'b0, dready}, 32'd0);
    end
    mready = 1;
    tick();
    check("w_dready", {31'b0, dready}, 32'd1);
    check("w_cleared", {26'b0, mvalid, mwrite, mwstb}, 32'd0);
    check("w_iready", {31'b0, iready}, 32'd0);
    dvalid = 0; mready = 0; dwrite = 0; dwstb = 4'h0;
    tick();
    check("w_dready_pulse", {31'b0, dready}, 32'd0);
    tick();

    // Simultaneous requests, data priority.
    iaddr = 32'h10; daddr = 32'h20; mrdata = 32'h0BADF00D;
    run_tie(1'b0, 3, order, first_c, min_gap, max_gap);
    check("dp_order", {24'b0, order}, 32'b00111000);
    check("dp_first", first_c, 32'd2);
    check("dp_min_gap", min_gap, 32'd3);
    check("dp_max_gap", max_gap, 32'd3);

    // Simultaneous requests, round-robin: data, fetch, data, fetch.
    run_tie(1'b1, 2, order, first_c, min_gap, max_gap);
    check("rr_order", {24'b0, order}, 32'b00001010);
    check("rr_first", first_c, 32'd2);
    check("rr_min_gap", min_gap, 32'd3);
    check("rr_max_gap", max_gap, 32'd3);
    check("rr_irdata", r_irdata, 32'h0BADF00D);

    // Reset mid-ISSUE.
    dvalid = 1; daddr = 32'h300; dwdata = 32'h11111111; dwstb = 4'b1111; dwrite = 1;
    tick();
    check("r_mvalid_pre", {27'b0, mvalid, mwstb}, 32'h1F);
    #2 reset = 1;
    #1;
    check("r_async_clear", {26'b0, mvalid, mwrite, mwstb}, 32'd0);
    dvalid = 0; dwrite = 0; dwstb = 4'h0;
    #1 reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r_no_ready", {30'b0, iready, dready}, 32'd0);
    end
    ivalid = 1; iaddr = 32'h40; mrdata = 32'h12345678; mready = 1;
    tick();
    check("r_fetch_maddr", maddr, 32'h40);
    tick();
    check("r_fetch_iready", {31'b0, iready}, 32'd1);
    check("r_fetch_irdata", irdata, 32'h12345678);
    ivalid = 0; mready = 0;
    tick();
    tick();

    // mready while idle must be ignored.
    mrdata = 32'hFFFFFFFF; mready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_ready", {29'b0, mvalid, iready, dready}, 32'd0);
      check("idle_irdata", irdata, 32'h12345678);
      check("idle_drdata", drdata, 32'h0);
    end
    mready = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
